// File: rtl/score_board_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : score_board_pkg
//  Purpose : Shared types for the issue-stage scoreboard: register address,
//            tracked-stage encoding, shadow-pipeline entry and operand select.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package score_board_pkg;

   localparam int SB_LANES  = 2;
   localparam int SB_STAGES = 3;

   typedef logic [4:0] reg_addr_t;

   // Where an operand value is taken from. Encoding doubles as
   // "stage index + 1" for the tracked stages.
   typedef enum logic [1:0] {
      SB_REGFILE = 2'd0,
      SB_EX      = 2'd1,
      SB_MEM     = 2'd2,
      SB_CMT     = 2'd3
   } sb_stage_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t dst;
      logic      load;
   } sb_entry_t;

   typedef struct packed {
      sb_stage_t stage;
      logic      lane;
   } sb_data_t;

endpackage : score_board_pkg
`default_nettype wire

// File: rtl/score_board_sb_lookup.sv
`default_nettype none
// ============================================================================
//  Module  : sb_lookup
//  Purpose : Combinational producer search for one source register over the
//            STAGES x LANES shadow pipeline. Youngest producer wins: EX over
//            MEM over CMT, and lane 1 over lane 0 within a stage.
//  Ports   : src       - source register address
//            entries   - shadow pipeline [stage][lane], stage 0 = EX
//            sel       - operand select {stage, lane}; REGFILE if no match
//            load_use  - matching producer is a load still in EX
//  Rev     : 1.0  initial release
// ============================================================================
module sb_lookup
   import score_board_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int STAGES = 3
) (
   input  reg_addr_t                          src,
   input  sb_entry_t [STAGES-1:0][LANES-1:0]  entries,
   output sb_data_t                           sel,
   output logic                               load_use
);

   // Walk from oldest to youngest so the last match written is the
   // highest-priority producer.
   always_comb begin
      sel      = '0;
      load_use = 1'b0;
      if (src != '0) begin
         for (int s = STAGES - 1; s >= 0; s--) begin
            for (int l = 0; l < LANES; l++) begin
               if (entries[s][l].valid && (entries[s][l].dst == src)) begin
                  sel.stage = sb_stage_t'(2'(s + 1));
                  sel.lane  = 1'(l);
                  load_use  = (s == 0) && entries[s][l].load;
               end
            end
         end
      end
   end

endmodule : sb_lookup
`default_nettype wire

// File: rtl/score_board.sv
`default_nettype none
// ============================================================================
//  Module  : score_board
//  Purpose : Issue-stage scoreboard and dual-issue scheduler. Tracks in-flight
//            destinations through EX/MEM/CMT, decides how many of the two
//            queue heads issue (in order) and produces bypass selects.
//  Ports   : clk, rst        - clock, synchronous active-high reset
//            iq_size         - valid queue heads (3 treated as 2)
//            cand_src        - [slot][operand] source registers
//            cand_dst        - [slot] destination register
//            cand_wen        - [slot] writes a register
//            cand_load       - [slot] is a load
//            stall           - freeze: no issue, shadow pipeline holds
//            flush           - drop all in-flight tracking
//            iq_pop_number   - instructions issued this cycle
//            score_board_data- operand selects {s1.op1,s1.op0,s0.op1,s0.op0}
//            issued_count    - statistics (SCORE_BOARD_STAT_EN), else 0
//            stall_count     - statistics (SCORE_BOARD_STAT_EN), else 0
//  Config  : define SCORE_BOARD_STAT_EN to build the statistics counters.
//  Rev     : 1.0  initial release
// ============================================================================
module score_board
   import score_board_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int STAGES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            iq_size,
   input  logic [1:0][1:0][4:0]  cand_src,
   input  logic [1:0][4:0]       cand_dst,
   input  logic [1:0]            cand_wen,
   input  logic [1:0]            cand_load,
   input  logic                  stall,
   input  logic                  flush,
   output logic [1:0]            iq_pop_number,
   output logic [3:0][2:0]       score_board_data,
   output logic [31:0]           issued_count,
   output logic [31:0]           stall_count
);

   sb_entry_t [STAGES-1:0][LANES-1:0] entries;

   sb_data_t [3:0] op_sel;
   logic     [3:0] op_load_use;

   logic slot0_hazard;
   logic slot1_hazard;
   logic slot1_raw;
   logic slot1_waw;
   logic [1:0] issue_en;

   // One lookup per operand; operand i = slot (i/2), operand index (i%2)
   generate
      for (genvar i = 0; i < 4; i++) begin : g_lookup
         sb_lookup #(
            .LANES  (LANES),
            .STAGES (STAGES)
         ) u_lookup (
            .src      (cand_src[i/2][i%2]),
            .entries  (entries),
            .sel      (op_sel[i]),
            .load_use (op_load_use[i])
         );
         assign score_board_data[i] = op_sel[i];
      end
   endgenerate

   // Hazards. Slot 1 cannot forward from slot 0 in the same cycle, so any
   // read of slot 0's destination (or a write to the same register) blocks it.
   always_comb begin
      slot0_hazard = op_load_use[0] | op_load_use[1];
      slot1_raw    = cand_wen[0] && (cand_dst[0] != '0) &&
                     ((cand_src[1][0] == cand_dst[0]) ||
                      (cand_src[1][1] == cand_dst[0]));
      slot1_waw    = cand_wen[0] && cand_wen[1] && (cand_dst[0] != '0) &&
                     (cand_dst[0] == cand_dst[1]);
      slot1_hazard = op_load_use[2] | op_load_use[3] | slot1_raw | slot1_waw;
   end

   always_comb begin
      iq_pop_number = 2'd0;
      if (!rst && !flush && !stall && (iq_size != 2'd0) && !slot0_hazard) begin
         iq_pop_number = ((iq_size >= 2'd2) && !slot1_hazard) ? 2'd2 : 2'd1;
      end
   end

   assign issue_en = {iq_pop_number == 2'd2, iq_pop_number != 2'd0};

   // Shadow pipeline: EX <- issued slots, then shift toward CMT.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         entries <= '0;
      end else if (!stall) begin
         for (int s = STAGES - 1; s > 0; s--) begin
            entries[s] <= entries[s-1];
         end
         for (int l = 0; l < LANES; l++) begin
            entries[0][l].valid <= issue_en[l] && cand_wen[l] && (cand_dst[l] != '0);
            entries[0][l].dst   <= cand_dst[l];
            entries[0][l].load  <= cand_load[l];
         end
      end
   end

`ifdef SCORE_BOARD_STAT_EN
   logic [31:0] issued_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         issued_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         issued_cnt <= issued_cnt + 32'(iq_pop_number);
         if ((iq_size != 2'd0) && (iq_pop_number == 2'd0)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign issued_count = issued_cnt;
   assign stall_count  = stall_cnt;
`else
   assign issued_count = '0;
   assign stall_count  = '0;
`endif

endmodule : score_board
`default_nettype wire

// File: doc/score_board.md
# score_board

Issue-stage scoreboard and dual-issue scheduler for the in-order pipeline. Each cycle it examines up to two issue-queue head entries, decides how many issue (0, 1 or 2, strictly in order), and produces per-operand bypass selects for the bypass network. To do this it tracks every in-flight destination register through the EX, MEM and CMT stages in a 3-stage × 2-lane shadow pipeline. It sits between `issue_queue`/`issue` and `bypass`, and its `score_board_data` output replaces the ad-hoc selection currently done in `issue`.

## Interface
Parameters:
- `LANES`, 2: issue width. Only 2 is supported.
- `STAGES`, 3: tracked stages after issue (EX, MEM, CMT).

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `iq_size`  in  2  — valid heads available: 0, 1 or 2. A value of 3 is treated as 2.
- `cand_src`  in  2×2×5  — source register addresses for slot 0 and slot 1, operands 0 and 1.
- `cand_dst`  in  2×5  — destination register per slot.
- `cand_wen`  in  2  — slot writes a register.
- `cand_load`  in  2  — slot is a load; its result is valid only from MEM onward.
- `stall`  in  1  — downstream freeze: nothing issues and the shadow pipeline holds.
- `flush`  in  1  — discard all in-flight tracking.
- `iq_pop_number`  out  2  — instructions issued this cycle.
- `score_board_data`  out  4×3  — operand select per operand, indexed {slot1.op1, slot1.op0, slot0.op1, slot0.op0}. Each entry is {stage[1:0], lane}. Stage encoding: 0 = REGFILE, 1 = EX, 2 = MEM, 3 = CMT.
- `issued_count`, `stall_count`  out  32 each  — statistics counters (see Configuration).

## Operation
- State is `entry[stage][lane] = {valid, dst, load}`. Entries with dst = 0 are never stored as valid.
- **Producer match for operand `s`:** search EX, then MEM, then CMT. Within a stage, lane 1 beats lane 0 (lane 1 is younger). Source `$0` always selects REGFILE.
- **Slot 0 hazard:** a matching producer is in EX with `load` set (load-use).
- **Slot 1 hazards:**
  - slot 1 has a load-use hazard of its own;
  - slot 1 reads slot 0's dst while slot 0 has `wen` set and dst ≠ 0;
  - both slots write the same nonzero dst (WAW).
- **Issue count:**
  - `iq_pop_number` = 0 if `stall`, `flush`, `rst`, `iq_size` = 0, or slot 0 has a hazard.
  - Otherwise it is 1 + (`iq_size` ≥ 2 and slot 1 has no hazard).
- **Next-state update:**
  - If `rst` or `flush`: all entries are cleared.
  - Else if `stall`: entries hold.
  - Else: CMT ← MEM, MEM ← EX, EX[l] ← slot l when l < `iq_pop_number` (valid = `wen` && dst ≠ 0); otherwise EX[l] is cleared, acting as a bubble.
- `score_board_data` is driven for all four operands regardless of issue. Consumers use it only for issued slots.

## Timing
- `iq_pop_number` and `score_board_data` are combinational from current state and inputs, in the same cycle.
- The shadow pipeline updates at the rising edge of `clk`. An instruction issued in cycle N appears in EX in cycle N+1, MEM in N+2 and CMT in N+3, and is untracked from N+4, after which the regfile holds the value.
- **Load-use:** a consumer in the cycle immediately after its load issues stalls exactly 1 cycle, then selects MEM.
- **Reset:** all entries are invalid and counters are 0. In that state `iq_pop_number` = 0 while `rst` is high, and every `score_board_data` entry is 0 (REGFILE).
- **Simultaneous events:**
  - `rst` beats `flush`, which beats `stall`.
  - `flush` with `iq_size` = 2 issues nothing.
  - Reset mid-stream drops all tracking at the next edge.

## Configuration
- **`SCORE_BOARD_STAT_EN` defined:**
  - `issued_count` adds `iq_pop_number` each edge.
  - `stall_count` increments each edge where `iq_size` ≠ 0 and `iq_pop_number` = 0.
  - Both wrap modulo 2^32 and are cleared by `rst` only.
- **Not defined:** both outputs are tied to 0 and no counter flops exist.

## Structure
- Add to `defines.svh`:
  - typedef `SB_STAGE` (REGFILE/EX/MEM/CMT);
  - typedef `SB_ENTRY` {valid, dst, load};
  - `SCORE_BOARD_DATA` as {`SB_STAGE`, lane};
  - `REG_ADDR` is reused.
- One sub-module, `sb_lookup`: combinational producer search for a single source address over the 6 entries, returning the select and a load-use flag. It is instantiated 4 times.

## Test plan
- **Reset and independent pair:** after reset, `iq_size` = 2, srcs {1,2}/{3,4}, dsts 5/6 → `iq_pop_number` = 2, all selects REGFILE. The next cycle, a reader of $6 selects {EX, lane 1}.
- **Intra-pair dependence:** slot 0 writes $7, slot 1 reads $7 → `iq_pop_number` = 1. The next cycle, slot 1 (now slot 0) issues with select {EX, lane 0}.
- **Load-use:** a load to $8 issues; the next cycle a reader of $8 → 0 issued and `stall_count` +1. The following cycle it issues with {MEM, lane}.
- **Youngest-producer priority:** $9 is written in CMT lane 0 and in EX lane 0 → the reader selects {EX, 0}. Two same-stage writers of $9 → select lane 1.
- **Hazard corners:** both slots write $10 → 1 issued. A read of $0 with a pending "write" to $0 → REGFILE, no stall.
- **Control priority:** `stall` held 3 cycles → entries unchanged, 0 issued. `flush` with a pending $11 → the next cycle a reader of $11 selects REGFILE.
